matrix_add_unpack: RTL and testbench
====================================

// Module: matrix_add_unpack
// PURPOSE
//   Reader for the packed pair-sum bus from the matrix adder: accepts one N_ELEM*ELEM_W-bit result
//   word per valid/ready handshake and serialises it into N_ELEM ELEM_W-bit elements, one per beat,
//   to the downstream store/compare logic. Zero-bubble back-to-back frames; counts completed frames.
// PARAMETERS
//   ELEM_W  16  width of one sum element
//   N_ELEM  8   elements per packed word (input width = N_ELEM*ELEM_W = 128)
// PORTS
//   clk        in   1                 rising-edge clock
//   rst_n      in   1                 asynchronous active-low reset
//   in_valid   in   1                 packed word present on in_data
//   in_ready   out  1                 block can take a packed word this cycle
//   in_data    in   N_ELEM*ELEM_W     packed sums; element 0 in MSBs [127:112], element 7 in [15:0]
//   out_valid  out  1                 out_data/out_idx/out_last hold a valid element
//   out_ready  in   1                 downstream accepts the element this cycle
//   out_data   out  ELEM_W            current element
//   out_idx    out  $clog2(N_ELEM)    index of current element, 0..N_ELEM-1
//   out_last   out  1                 high with element N_ELEM-1
//   frame_cnt  out  16                completed frames (last element accepted), wraps 0xFFFF->0
// BEHAVIOUR
//   - Reset (rst_n low, async): state IDLE; out_valid=0, out_data=0, out_idx=0, out_last=0,
//     frame_cnt=0, holding register cleared; any partially sent frame is discarded.
//   - FSM: IDLE -> SEND on in_valid&in_ready. SEND -> SEND on element accept unless last.
//     SEND on last accept: -> SEND with new word if in_valid, else -> IDLE.
//   - in_ready (combinational) = (state==IDLE) | (out_valid & out_ready & out_last). High during reset
//     (IDLE), but no transfer is taken while rst_n is low.
//   - Accept: in_data copied to holding register; element 0 presented next cycle (latency 1:
//     in accept at edge t -> out_valid=1, out_idx=0 after edge t).
//   - Element k = hold[(N_ELEM-1-k)*ELEM_W +: ELEM_W]; out_data, out_idx, out_last registered.
//   - Element accepted when out_valid & out_ready; then idx increments, next element after edge.
//   - Stall: while out_valid & !out_ready, out_data/out_idx/out_last held stable; in_data ignored.
//   - Last accept with in_valid=1: new word loaded same edge, its element 0 appears next cycle;
//     no idle cycle between frames. Without in_valid: out_valid drops to 0 next cycle.
//   - frame_cnt increments on the edge the last element is accepted, modulo 2^16.
//   - in_valid with in_ready=0 has no effect; upstream must hold the word (no loss, no duplication).
// TESTING
//   1 Reset: assert rst_n=0 mid-frame (idx=3) -> out_valid=0, out_idx=0, frame_cnt=0 immediately.
//   2 Single frame, out_ready=1: in_data={16'h0001,16'h0002,...,16'h0008} -> out_data 1..8 on 8
//     consecutive cycles starting 1 cycle after accept, out_last only with 8, frame_cnt=1, in_ready=0
//     during elements 0-6.
//   3 Back-to-back: in_valid held with 2 words (A=all 16'hAAAA, B=all 16'h5555), out_ready=1 ->
//     16 consecutive valid beats, no gap, 8xAAAA then 8x5555, frame_cnt=2.
//   4 Backpressure: out_ready toggled 1,0,0,1,... -> out_data/out_idx unchanged across stalled
//     cycles, every element delivered exactly once, in order.
//   5 Wrap: force 65536 frames (or preload via hierarchical write of 16'hFFFF) -> frame_cnt 0xFFFF->0.
//   6 Max values: elements 16'hFFFF and 16'h0000 alternating -> out_data exact, no bit crossing.

Source files
------------

// File: rtl/matrix_add_unpack_if.sv
// Handshake bundle between the matrix adder's packed result bus and the element
// stream that feeds the store/compare logic.
interface matrix_add_unpack_if #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 8
);
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [N_ELEM*ELEM_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ELEM_W-1:0]        out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic [15:0]              frame_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, frame_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, frame_cnt
  );
endinterface

// File: rtl/matrix_add_unpack.sv
// Serialises one packed N_ELEM x ELEM_W sum word into N_ELEM element beats,
// element 0 taken from the MSBs; back-to-back words run without a bubble.
module matrix_add_unpack #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_add_unpack_if.slave   bus
);
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int WORD_W = N_ELEM * ELEM_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state_q;
  logic [WORD_W-1:0]              hold_q;
  logic [N_ELEM-1:0][ELEM_W-1:0]  elem;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [ELEM_W-1:0]              data_q;
  logic                           valid_q, last_q;
  logic [15:0]                    frame_cnt_q;
  logic                           out_acc, last_acc, load;

  // Lane k of the held word, MSB-first so lane 0 is the first element sent.
  for (genvar k = 0; k < N_ELEM; k++) begin : g_lane
    assign elem[k] = hold_q[(N_ELEM-1-k)*ELEM_W +: ELEM_W];
  end

  assign out_acc  = valid_q & bus.out_ready;
  assign last_acc = out_acc & last_q;
  assign load     = bus.in_valid & bus.in_ready;
  assign idx_d    = idx_q + IDX_W'(1);

  assign bus.in_ready  = (state_q == IDLE) | last_acc;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.frame_cnt = frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (last_acc) frame_cnt_q <= frame_cnt_q + 16'd1;

      // A load wins over the end-of-frame drop so the next word follows with no gap.
      if (load) begin
        hold_q  <= bus.in_data;
        data_q  <= bus.in_data[WORD_W-1 -: ELEM_W];
        idx_q   <= '0;
        last_q  <= (N_ELEM == 1);
        valid_q <= 1'b1;
        state_q <= SEND;
      end else if (last_acc) begin
        idx_q   <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
        state_q <= IDLE;
      end else if (out_acc) begin
        idx_q  <= idx_d;
        data_q <= elem[idx_d];
        last_q <= (idx_d == IDX_W'(N_ELEM-1));
      end
    end
  end
endmodule

// File: tb/tb_matrix_add_unpack.sv
// Bench for matrix_add_unpack: constant vector table, directed multi-cycle
// sequences and random traffic checked against a queue-based element model.
module tb_matrix_add_unpack;
  localparam int W = 16;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_add_unpack_if #(.ELEM_W(W), .N_ELEM(N)) bus ();
  matrix_add_unpack #(.ELEM_W(W), .N_ELEM(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    int          idx;
  } elem_t;

  typedef struct {
    logic [127:0]      data;
    logic [0:7][15:0]  exp;
  } vec_t;

  elem_t       expq[$];
  int          acc_cyc[$];
  int          exp_frames = 0;
  logic [15:0] fc_off = 16'h0;
  int          cyc = 0;
  int          rdy_mode = 0;

  // Downstream ready: 0 = always, 1 = random, 2 = 1,0,0 repeating, else never.
  initial begin
    int pat;
    pat = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: begin bus.out_ready = (pat % 3 == 0); pat++; end
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Reference model: a word accepted upstream becomes N queued elements; every
  // downstream accept must match the queue head. Checked mid-cycle.
  initial begin
    elem_t       e;
    logic        st_v, st_l;
    logic [15:0] st_d, fexp;
    logic [2:0]  st_i;
    st_v = 1'b0; st_l = 1'b0; st_d = '0; st_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        expq.delete();
        exp_frames = 0;
        st_v = 1'b0;
      end else begin
        fexp = 16'(exp_frames) + fc_off;
        check("out_valid", 128'(bus.out_valid), 128'(expq.size() != 0));
        check("in_ready", 128'(bus.in_ready),
              128'(expq.size() == 0 || (expq.size() == 1 && bus.out_ready)));
        check("frame_cnt", 128'(bus.frame_cnt), 128'(fexp));
        if (st_v) begin
          check("stall_valid", 128'(bus.out_valid), 128'(1'b1));
          check("stall_data", 128'(bus.out_data), 128'(st_d));
          check("stall_idx", 128'(bus.out_idx), 128'(st_i));
          check("stall_last", 128'(bus.out_last), 128'(st_l));
        end
        st_v = bus.out_valid & ~bus.out_ready;
        st_d = bus.out_data; st_i = bus.out_idx; st_l = bus.out_last;
        if (bus.out_valid && bus.out_ready && expq.size() != 0) begin
          e = expq.pop_front();
          check("elem_data", 128'(bus.out_data), 128'(e.d));
          check("elem_idx", 128'(bus.out_idx), 128'(e.idx));
          check("elem_last", 128'(bus.out_last), 128'(e.idx == N-1));
          acc_cyc.push_back(cyc);
          if (e.idx == N-1) exp_frames++;
        end
        if (bus.in_valid && bus.in_ready) begin
          for (int k = 0; k < N; k++) begin
            e.d = 16'(bus.in_data >> (W * (N-1-k)));
            e.idx = k;
            expq.push_back(e);
          end
        end
      end
    end
  end

  // Present a word and hold it until taken; returns just after the accepting edge.
  task automatic send(input logic [127:0] w);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    do begin @(negedge clk); t++; end while (!bus.in_ready && t < 300);
    if (!bus.in_ready) begin
      check("send_timeout", 128'(0), 128'(1));
      bus.in_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while ((expq.size() != 0 || bus.out_valid) && t < 600);
    if (bus.out_valid) check("drain_timeout", 128'(bus.out_valid), 128'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  vec_t        tbl[4];
  logic [15:0] f0;
  int          t;

  initial begin
    tbl[0].data = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    tbl[0].exp  = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    tbl[1].data = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    tbl[1].exp  = {16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0};
    tbl[2].data = 128'h0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF;
    tbl[2].exp  = {16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF};
    tbl[3].data = 128'h8000_0001_7FFF_FFFE_00FF_FF00_0F0F_F0F0;
    tbl[3].exp  = {16'h8000, 16'h0001, 16'h7FFF, 16'hFFFE, 16'h00FF, 16'hFF00, 16'h0F0F, 16'hF0F0};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_data", 128'(bus.out_data), 128'(0));
    check("rst_out_idx", 128'(bus.out_idx), 128'(0));
    check("rst_out_last", 128'(bus.out_last), 128'(0));
    check("rst_frame_cnt", 128'(bus.frame_cnt), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors at full downstream rate.
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].data);
      bus.in_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
        t = 0;
        do begin @(negedge clk); t++; end while (!(bus.out_valid && bus.out_ready) && t < 50);
        check($sformatf("tbl%0d_data%0d", i, k), 128'(bus.out_data), 128'(tbl[i].exp[k]));
        check($sformatf("tbl%0d_idx%0d", i, k), 128'(bus.out_idx), 128'(k));
        check($sformatf("tbl%0d_last%0d", i, k), 128'(bus.out_last), 128'(k == N-1));
      end
      drain();
    end
    check("tbl_frames", 128'(bus.frame_cnt), 128'(4));

    // Back-to-back frames: 16 beats on consecutive cycles.
    acc_cyc.delete();
    f0 = bus.frame_cnt;
    send({8{16'hAAAA}});
    send({8{16'h5555}});
    bus.in_valid = 1'b0;
    drain();
    check("b2b_beats", 128'(acc_cyc.size()), 128'(16));
    if (acc_cyc.size() == 16) check("b2b_gap", 128'(acc_cyc[15] - acc_cyc[0]), 128'(15));
    check("b2b_frames", 128'(bus.frame_cnt), 128'(16'(f0 + 16'd2)));

    // Backpressure: fixed 1,0,0 pattern, then random ready with random upstream gaps.
    rdy_mode = 2;
    send(rnd_word());
    bus.in_valid = 1'b0;
    drain();
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) begin
      send(rnd_word());
      if ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // Asynchronous reset mid-frame at element 3.
    send(tbl[3].data);
    bus.in_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.out_idx != 3 && t < 50);
    check("mid_idx_reached", 128'(bus.out_idx), 128'(3));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_idx", 128'(bus.out_idx), 128'(0));
    check("mid_rst_last", 128'(bus.out_last), 128'(0));
    check("mid_rst_frame_cnt", 128'(bus.frame_cnt), 128'(0));
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Counter wrap from a preloaded 0xFFFF.
    @(posedge clk); #1;
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    fc_off = 16'hFFFF - 16'(exp_frames);
    check("wrap_pre", 128'(bus.frame_cnt), 128'(16'hFFFF));
    send(rnd_word());
    bus.in_valid = 1'b0;
    drain();
    check("wrap_post", 128'(bus.frame_cnt), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
